uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- Parametrised serial frame transmitter; successor to the fixed 7-bit/even-parity/1-bit-per-clock transmitter.
- Sends an idle-high asynchronous frame: start bit (0), DATA_W data bits LSB first, optional parity bit, then STOP_BITS stop bits (1).
- Adds configurable width, bit period, parity mode and stop bits, plus a valid/ready input handshake with busy/done status.
- Sits between a byte/word producer (FIFO or controller) and the off-chip serial pin.

Parameters:
DATA_W, 7, number of data bits per frame (1..16).
CLKS_PER_BIT, 1, clk cycles each bit is held on serial_out (>=1).
PARITY, 1, 0 = none, 1 = even, 2 = odd; other values unsupported.
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
clk  input  1  system clock, rising-edge.
rstn  input  1  reset, asynchronous, active-low.
in_valid  input  1  producer has a word on in_data.
in_ready  output  1  block can accept a word; high only in IDLE.
in_data  input  DATA_W  word to send; sampled only on the accepting edge.
serial_out  output  1  serial line, idle high.
busy  output  1  frame in progress; equals the inverse of in_ready.
done  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Clock and reset: clock clk; reset rstn, asynchronous, active-low.
- Reset values: serial_out=1, in_ready=1, busy=0, done=0, state=IDLE, all counters 0, data/parity registers 0.
- Reset asserted mid-frame: frame is abandoned and serial_out returns to 1 immediately (asynchronously); nothing resumes after release.
- Frame length: N = 1 + DATA_W + (PARITY!=0 ? 1 : 0) + STOP_BITS bits; total N*CLKS_PER_BIT cycles.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept: a word is accepted on a rising edge k where in_valid && in_ready.
  - At that edge, in_data is latched into a shift/hold register.
  - Parity is computed from the latched value: even = XOR of the data bits; odd = its inverse.
  - State goes to START; serial_out becomes 0; in_ready becomes 0; busy becomes 1.
- Bit timing: every bit is held exactly CLKS_PER_BIT cycles.
  - Bit j of the frame (0 = start bit) is driven from edge k + j*CLKS_PER_BIT.
  - Data bit i is frame bit 1+i, sent LSB first.
  - Parity bit (when enabled) follows the MSB.
  - Stop bits drive 1.
- Bit counter: counts 0..DATA_W-1 in DATA and 0..STOP_BITS-1 in STOP.
- Cycle counter: counts 0..CLKS_PER_BIT-1 and advances the bit on its terminal count. With CLKS_PER_BIT=1 a bit advances every cycle.
- PARITY=0: DATA goes directly to STOP.
- End of frame: at edge k + N*CLKS_PER_BIT:
  - state goes to IDLE; in_ready=1, busy=0; serial_out stays 1.
  - done=1 for exactly that one cycle.
- Back-to-back: in_valid held high across the end of frame is not accepted at the end-of-frame edge (in_ready was 0 before it).
  - The earliest next accept is edge k + N*CLKS_PER_BIT + 1.
  - This guarantees at least one extra idle-high cycle after the stop bits.
- During a frame: in_valid and in_data are ignored; changing in_data mid-frame has no effect on the bits sent.
- in_valid low in IDLE: line stays 1 indefinitely and no counters run.
- All outputs are registered; serial_out is glitch-free.

Test Plan:
- Defaults, send 7'h55, CLKS_PER_BIT=1 -> serial_out after the accept edge is 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, parity 0, stop). done pulses at edge k+10. in_ready is back at 1 at k+10.
- PARITY=2, DATA_W=8, send 8'h00 -> parity bit = 1; frame = 0, eight 0s, 1, 1 (11 bits).
- CLKS_PER_BIT=4, STOP_BITS=2, PARITY=0, DATA_W=8, send 8'h81 -> each bit held exactly 4 cycles; frame = 44 cycles. done at k+44. Stop level lasts 8 cycles before IDLE.
- in_valid held high with in_data toggling every cycle during a frame -> only the word present at the accept edge is transmitted. The second accept occurs at k+N*CLKS_PER_BIT+1, never earlier.
- rstn pulsed low during data bit 3 -> serial_out=1 and in_ready=1 immediately. No further bits after release; the next accepted word sends a complete, correct frame.
- Idle with in_valid=0 for 50 cycles -> serial_out constantly 1, busy=0, done never pulses.

Source files
------------

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - parametrised asynchronous serial frame transmitter
// Start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits; idle high.
module uart_tx_frame #(
    parameter int DATA_W       = 7,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              serial_out,
    output logic              busy,
    output logic              done
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              par_bit, par_bit_n;
    logic [BW-1:0]     bit_cnt, bit_cnt_n;
    logic [CW-1:0]     clk_cnt, clk_cnt_n;
    logic              tx, tx_n;
    logic              done_r, done_n;
    logic              tick;
    logic              last_data;
    logic              last_stop;

    assign tick      = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign last_data = (bit_cnt == BW'(DATA_W - 1));
    assign last_stop = (bit_cnt == BW'(STOP_BITS - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            par_bit <= 1'b0;
            bit_cnt <= '0;
            clk_cnt <= '0;
            tx      <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            par_bit <= par_bit_n;
            bit_cnt <= bit_cnt_n;
            clk_cnt <= clk_cnt_n;
            tx      <= tx_n;
            done_r  <= done_n;
        end
    end

    // The data register shifts right as each bit is launched, so bit 0 is always next.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        par_bit_n = par_bit;
        bit_cnt_n = bit_cnt;
        clk_cnt_n = '0;
        tx_n      = tx;
        done_n    = 1'b0;
        if (state != ST_IDLE && !tick) begin
            clk_cnt_n = clk_cnt + CW'(1);
        end
        case (state)
            ST_IDLE: begin
                tx_n = 1'b1;
                if (in_valid) begin
                    state_n   = ST_START;
                    shreg_n   = in_data;
                    par_bit_n = (PARITY == 2) ? ~(^in_data) : (^in_data);
                    bit_cnt_n = '0;
                    tx_n      = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_n   = ST_DATA;
                    bit_cnt_n = '0;
                    tx_n      = shreg[0];
                    shreg_n   = shreg >> 1;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (last_data) begin
                        bit_cnt_n = '0;
                        if (PARITY != 0) begin
                            state_n = ST_PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n = ST_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                        tx_n      = shreg[0];
                        shreg_n   = shreg >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_n   = ST_STOP;
                    bit_cnt_n = '0;
                    tx_n      = 1'b1;
                end
            end
            ST_STOP: begin
                tx_n = 1'b1;
                if (tick) begin
                    if (last_stop) begin
                        state_n   = ST_IDLE;
                        bit_cnt_n = '0;
                        done_n    = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    assign serial_out = tx;
    assign in_ready   = (state == ST_IDLE);
    assign busy       = ~in_ready;
    assign done       = done_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame
// Three configurations run side by side against a frame-level model.
module tb_uart_tx_frame;

    logic        clk  = 1'b0;
    logic        rstn = 1'b1;
    logic        valid [3];
    logic [15:0] data  [3];
    logic        ready [3];
    logic        so    [3];
    logic        busy  [3];
    logic        done  [3];

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic int dw(int g);
        case (g)
            0:       return 7;
            default: return 8;
        endcase
    endfunction

    function automatic int cpb(int g);
        return (g == 2) ? 4 : 1;
    endfunction

    function automatic int par(int g);
        case (g)
            0:       return 1;
            1:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int stp(int g);
        return (g == 2) ? 2 : 1;
    endfunction

    function automatic int flen(int g);
        return 1 + dw(g) + ((par(g) != 0) ? 1 : 0) + stp(g);
    endfunction

    function automatic logic [15:0] mask(int g);
        logic [16:0] m;
        m = (17'h1 << dw(g)) - 17'h1;
        return m[15:0];
    endfunction

    function automatic logic frame_bit(int g, logic [15:0] w, int j);
        logic p;
        p = ^(w & mask(g));
        if (par(g) == 2) p = ~p;
        if (j == 0) return 1'b0;
        if (j <= dw(g)) return w[j-1];
        if (par(g) != 0 && j == dw(g) + 1) return p;
        return 1'b1;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        uart_tx_frame #(
            .DATA_W      (dw(g)),
            .CLKS_PER_BIT(cpb(g)),
            .PARITY      (par(g)),
            .STOP_BITS   (stp(g))
        ) u_dut (
            .clk       (clk),
            .rstn      (rstn),
            .in_valid  (valid[g]),
            .in_ready  (ready[g]),
            .in_data   (data[g][dw(g)-1:0]),
            .serial_out(so[g]),
            .busy      (busy[g]),
            .done      (done[g])
        );
    end

    // Model: cycles elapsed since the accept edge of the frame in flight.
    int          t     [3];
    bit          act   [3];
    bit          mdone [3];
    logic [15:0] word  [3];

    always @(posedge clk or negedge rstn) begin
        for (int g = 0; g < 3; g++) begin
            if (!rstn) begin
                act[g]   <= 1'b0;
                t[g]     <= 0;
                mdone[g] <= 1'b0;
                word[g]  <= '0;
            end else if (act[g]) begin
                if (t[g] + 1 == flen(g) * cpb(g)) begin
                    act[g]   <= 1'b0;
                    t[g]     <= 0;
                    mdone[g] <= 1'b1;
                end else begin
                    t[g]     <= t[g] + 1;
                    mdone[g] <= 1'b0;
                end
            end else begin
                mdone[g] <= 1'b0;
                if (valid[g]) begin
                    act[g]  <= 1'b1;
                    t[g]    <= 0;
                    word[g] <= data[g] & mask(g);
                end
            end
        end
    end

    function automatic logic exp_so(int g);
        return act[g] ? frame_bit(g, word[g], t[g] / cpb(g)) : 1'b1;
    endfunction

    task automatic chk(string nm, logic [63:0] actual, logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errs++;
            $display("FAIL %s actual=%0h required=%0h", nm, actual, required);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("serial_out[%0d]", g), 64'(so[g]), 64'(exp_so(g)));
            chk($sformatf("in_ready[%0d]", g), 64'(ready[g]), 64'(!act[g]));
            chk($sformatf("busy[%0d]", g), 64'(busy[g]), 64'(act[g]));
            chk($sformatf("done[%0d]", g), 64'(done[g]), 64'(mdone[g]));
        end
    end

    task automatic run_frame(input int g, input logic [15:0] w, input int len,
                             output logic [63:0] cap, output logic [63:0] dcap,
                             output logic [63:0] rcap);
        cap  = '0;
        dcap = '0;
        rcap = '0;
        @(negedge clk);
        valid[g] = 1'b1;
        data[g]  = w;
        @(negedge clk);
        valid[g] = 1'b0;
        for (int c = 0; c < len; c++) begin
            cap[c]  = so[g];
            dcap[c] = done[g];
            rcap[c] = ready[g];
            data[g] = 16'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        while (!ready[g] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("idle_timeout[%0d]", g), 64'(ready[g]), 64'(1));
    endtask

    logic [63:0] cap, dcap, rcap;
    logic [14:0] rc;
    logic [9:0]  mbits;
    int          zeros, bad;

    initial begin
        for (int g = 0; g < 3; g++) begin
            valid[g] = 1'b0;
            data[g]  = '0;
        end
        #1 rstn = 1'b0;
        @(negedge clk);
        chk("reset_serial_out", 64'(so[0]), 64'(1));
        chk("reset_in_ready", 64'(ready[0]), 64'(1));
        chk("reset_busy", 64'(busy[2]), 64'(0));
        chk("reset_done", 64'(done[1]), 64'(0));
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int j = 0; j < 10; j++) mbits[j] = frame_bit(0, 16'h55, j);
        chk("model_frame_55", 64'(mbits), 64'(10'b1010101010));

        run_frame(0, 16'h55, 11, cap, dcap, rcap);
        chk("frame_55_bits", 64'(cap[10:0]), 64'(11'b11010101010));
        chk("frame_55_done", 64'(dcap[10:0]), 64'(11'b10000000000));
        chk("frame_55_ready", 64'(rcap[10:0]), 64'(11'b10000000000));

        run_frame(1, 16'h00, 12, cap, dcap, rcap);
        chk("frame_odd_00_bits", 64'(cap[10:0]), 64'(11'b11000000000));
        chk("frame_odd_00_done", 64'(dcap[11:0]), 64'(12'h800));

        run_frame(2, 16'h81, 45, cap, dcap, rcap);
        chk("frame_81_bits", 64'(cap[43:0]), 64'(44'hFFF000000F0));
        chk("frame_81_done", 64'(dcap[44:0]), 64'(45'h100000000000));
        chk("frame_81_ready", 64'(rcap[44]), 64'(1));

        // Back-to-back with in_data churning every cycle.
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 16'h2A;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            rc[c]   = ready[0];
            data[0] = 16'($urandom);
        end
        valid[0] = 1'b0;
        chk("back_to_back_ready", 64'(rc), 64'(15'h0400));
        wait_idle(0);

        // Asynchronous reset during data bit 3.
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 16'h6B;
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("async_reset_serial_out", 64'(so[0]), 64'(1));
        chk("async_reset_in_ready", 64'(ready[0]), 64'(1));
        repeat (2) @(negedge clk);
        rstn  = 1'b1;
        zeros = 0;
        repeat (15) begin
            @(negedge clk);
            if (so[0] !== 1'b1) zeros++;
        end
        chk("no_resume_after_reset", 64'(zeros), 64'(0));
        run_frame(0, 16'h13, 11, cap, dcap, rcap);
        chk("frame_13_after_reset", 64'(cap[9:0]), 64'(10'b1100100110));

        bad = 0;
        repeat (50) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++)
                if (so[g] !== 1'b1 || busy[g] !== 1'b0 || done[g] !== 1'b0) bad++;
        end
        chk("idle_50_cycles", 64'(bad), 64'(0));

        repeat (3000) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                valid[g] = ($urandom_range(0, 3) == 0);
                data[g]  = 16'($urandom);
            end
        end
        for (int g = 0; g < 3; g++) valid[g] = 1'b0;
        for (int g = 0; g < 3; g++) wait_idle(g);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
